ttc_intr_status_lite24: RTL



---
 rtl/ttc_intr_status_lite24_if.sv | 19 +
 rtl/ttc_intr_status_lite24.sv | 62 ++++++
 2 files changed

// File: rtl/ttc_intr_status_lite24_if.sv
// Counter-to-collector interrupt level bundle for one lite timer channel.
// The counter drives the levels; the status collector consumes them.
interface ttc_intr_status_lite24_if;
  logic       interval_intr24;
  logic [3:1] match_intr24;
  logic       overflow_intr24;

  modport master (
    output interval_intr24,
    output match_intr24,
    output overflow_intr24
  );

  modport slave (
    input interval_intr24,
    input match_intr24,
    input overflow_intr24
  );
endinterface

// File: rtl/ttc_intr_status_lite24.sv
// Sticky interrupt status, overrun flag, enable mask and registered irq
// for one lite timer-counter channel.
module ttc_intr_status_lite24 (
  input  logic                     n_p_reset24,
  input  logic                     pclk24,
  input  logic [15:0]              pwdata24,
  input  logic                     intr_en_reg_sel24,
  input  logic                     intr_status_rd24,
  ttc_intr_status_lite24_if.slave  cnt_if,
  output logic [5:0]               intr_status_out24,
  output logic [5:0]               intr_en_reg_out24,
  output logic                     irq24
);

  logic [4:0] w_src;
  logic [4:0] w_rise;
  logic       w_ovr_set;
  logic [5:0] w_stat_nxt;
  logic       w_unused_pwdata;

  logic [4:0] r_prev;
  logic [5:0] r_stat;
  logic [5:0] r_en;
  logic       r_irq;

  assign w_src = {cnt_if.overflow_intr24,
                  cnt_if.match_intr24,
                  cnt_if.interval_intr24};

  assign w_unused_pwdata = ^pwdata24[15:6];

  // A new event always wins over a coincident clear-on-read.
  always_comb begin
    w_rise     = w_src & ~r_prev;
    w_ovr_set  = (|(w_rise & r_stat[4:0])) & ~intr_status_rd24;
    w_stat_nxt = r_stat;
    w_stat_nxt[4:0] = w_rise
                    | (intr_status_rd24 ? 5'b0 : r_stat[4:0]);
    w_stat_nxt[5]   = w_ovr_set
                    | (~intr_status_rd24 & r_stat[5]);
  end

  always_ff @(posedge pclk24 or negedge n_p_reset24) begin
    if (!n_p_reset24) begin
      r_prev <= 5'b0;
      r_stat <= 6'b0;
      r_en   <= 6'b0;
      r_irq  <= 1'b0;
    end else begin
      r_prev <= w_src;
      r_stat <= w_stat_nxt;
      if (intr_en_reg_sel24)
        r_en <= pwdata24[5:0];
      r_irq  <= |(r_stat & r_en);
    end
  end

  assign intr_status_out24 = r_stat;
  assign intr_en_reg_out24 = r_en;
  assign irq24             = r_irq;

endmodule
